// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg
//   Shared constants for the 7-segment scan driver: glyph codes for the
//   board's tubes, bit order {dp,g,f,e,d,c,b,a}, active-high segments.
//   GLYPH_EMP is the all-off pattern and the default blank code.
package seg_scan_display_pkg;

    localparam logic [7:0] GLYPH_F   = 8'h71;
    localparam logic [7:0] GLYPH_R   = 8'h50;
    localparam logic [7:0] GLYPH_E   = 8'h79;
    localparam logic [7:0] GLYPH_A   = 8'h77;
    localparam logic [7:0] GLYPH_U   = 8'h1C;
    localparam logic [7:0] GLYPH_T   = 8'h78;
    localparam logic [7:0] GLYPH_O   = 8'h5C;
    localparam logic [7:0] GLYPH_S   = 8'h6D;
    localparam logic [7:0] GLYPH_D   = 8'h5E;
    localparam logic [7:0] GLYPH_Y   = 8'h6E;
    localparam logic [7:0] GLYPH_P   = 8'h73;
    localparam logic [7:0] GLYPH_L   = 8'h38;
    localparam logic [7:0] GLYPH_ONE = 8'h06;
    localparam logic [7:0] GLYPH_TWO = 8'h5B;
    localparam logic [7:0] GLYPH_EMP = 8'h00;

    // Width of an index able to address n items (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_display_tick.sv
// scan_tick_gen
//   Free-running prescaler producing a one-cycle clock-enable tick every
//   DIV clk cycles. div_cnt runs 0..DIV-1; tick is high while div_cnt is
//   at its last value, after which it wraps to 0.
// Ports:
//   clk    in   system clock
//   rst_n  in   async active-low reset
//   tick   out  clock-enable strobe, one cycle every DIV cycles
module scan_tick_gen
    import seg_scan_display_pkg::*;
#(
    parameter int DIV = 200000
)(
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = idx_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed 7-segment driver. Scans NUM_DIGITS digits one-hot on
//   seg_en, routing the current glyph to tube1 (digits below BANK_SPLIT)
//   or tube2 (the rest); the idle bank shows BLANK_CODE. Frames are
//   double-buffered: a load lands in a shadow copy and is promoted only at
//   the frame wrap, so text never changes mid-scan.
//   Optional blinking is compiled in with the macro SEG_BLINK_EN.
// Ports:
//   clk         in   system clock
//   rst_n       in   async active-low reset
//   load        in   1-cycle strobe capturing frame_i / blink_i
//   frame_i     in   glyph for digit k at [8k+7:8k]
//   blink_i     in   per-digit blink mask (SEG_BLINK_EN builds only)
//   seg_en      out  one-hot digit enable
//   tube1       out  segment pattern, low bank
//   tube2       out  segment pattern, high bank
//   frame_done  out  1-cycle pulse when the last slot ends
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int         NUM_DIGITS   = 8,
    parameter int         BANK_SPLIT   = 4,
    parameter int         SCAN_DIV     = 200000,
    parameter int         BLINK_FRAMES = 64,
    parameter logic [7:0] BLANK_CODE   = GLYPH_EMP
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [8*NUM_DIGITS-1:0] frame_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              tube1,
    output logic [7:0]              tube2,
    output logic                    frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;
    logic                    wrap;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [8*NUM_DIGITS-1:0] act_frame;
    logic [8*NUM_DIGITS-1:0] shd_frame;
    logic [8*NUM_DIGITS-1:0] act_frame_next;
    logic                    pending;
    logic [7:0]              glyph_next;
    logic                    blank_next;
    logic [7:0]              shown;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wrap     = tick && (idx == IDX_LAST);
    assign idx_next = wrap ? '0 : idx + IDX_W'(1);

    // Frame that is active after this edge. The output update at a wrap
    // must already see the promoted (or bypassed) frame so slot 0 of the
    // new frame shows the new text.
    always_comb begin
        act_frame_next = act_frame;
        if (wrap && load) begin
            act_frame_next = frame_i;
        end else if (wrap && pending) begin
            act_frame_next = shd_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            act_frame <= {NUM_DIGITS{BLANK_CODE}};
            shd_frame <= {NUM_DIGITS{BLANK_CODE}};
            pending   <= 1'b0;
        end else begin
            act_frame <= act_frame_next;
            if (load && !wrap) begin
                shd_frame <= frame_i;
                pending   <= 1'b1;
            end else if (wrap) begin
                pending   <= 1'b0;
            end
            if (tick) begin
                idx <= idx_next;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FC_W = idx_width(BLINK_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] act_blink;
    logic [NUM_DIGITS-1:0] shd_blink;
    logic [NUM_DIGITS-1:0] act_blink_next;
    logic [FC_W-1:0]       frame_cnt;
    logic                  phase_on;
    logic                  phase_on_next;

    always_comb begin
        act_blink_next = act_blink;
        if (wrap && load) begin
            act_blink_next = blink_i;
        end else if (wrap && pending) begin
            act_blink_next = shd_blink;
        end
    end

    // Phase flips at the wrap ending the last frame of a half-period; the
    // new phase applies from slot 0 of the following frame.
    assign phase_on_next = (wrap && frame_cnt == FC_LAST) ? !phase_on : phase_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_blink <= '0;
            shd_blink <= '0;
            frame_cnt <= '0;
            phase_on  <= 1'b1;
        end else begin
            act_blink <= act_blink_next;
            phase_on  <= phase_on_next;
            if (load && !wrap) begin
                shd_blink <= blink_i;
            end
            if (wrap) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
            end
        end
    end

    assign blank_next = !phase_on_next && act_blink_next[idx_next];
`else
    logic unused_blink;
    assign unused_blink = ^blink_i;
    assign blank_next   = 1'b0;
`endif

    assign glyph_next = act_frame_next[8*int'(idx_next) +: 8];
    assign shown      = blank_next ? BLANK_CODE : glyph_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_en     <= NUM_DIGITS'(1);
            tube1      <= BLANK_CODE;
            tube2      <= BLANK_CODE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                seg_en <= NUM_DIGITS'(1) << idx_next;
                if (int'(idx_next) < BANK_SPLIT) begin
                    tube1 <= shown;
                    tube2 <= BLANK_CODE;
                end else begin
                    tube1 <= BLANK_CODE;
                    tube2 <= shown;
                end
            end
        end
    end

endmodule
